// File: rtl/ps2_kbd_pkg.sv
// Shared keyboard-path constants and the PS/2 frame validity check.
// Imported by the receiver top and its scan-code FIFO.
package ps2_kbd_pkg;

    localparam int KbWidth        = 8;
    localparam int PS2_FRAME_BITS = 11;
    localparam logic [31:0] KBD_ADDR = 32'hFFFF_0100;
    localparam logic [31:0] KBD_LEN  = 32'd4;

    // shreg holds {parity, d7..d0, start}; stop is the bit arriving with the last fall.
    function automatic logic frame_ok(input logic [9:0] shreg, input logic stop);
        return (shreg[0] == 1'b0) && stop && (^shreg[9:1]);
    endfunction

endpackage

// File: rtl/ps2_kbd_fifo.sv
// Show-ahead synchronous scan-code FIFO: the head is always visible on rdata.
// Pointers carry one extra wrap bit to tell full from empty.
module kbd_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = KbWidth
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!clrn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver: pin synchronizer, 11-bit frame deserializer with
// timeout, and the scan-code FIFO read by the MMIO keyboard path.
module ps2_kbd
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    input  logic               sig_rd_kb,
    output logic [KbWidth-1:0] kb_rdata,
    output logic               kb_ready,
    output logic               overflow,
    output logic               frame_err
);

    localparam int         IdleW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] STOP_IDX = 4'(PS2_FRAME_BITS - 1);

    function automatic logic [IdleW-1:0] sat_inc(input logic [IdleW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic               ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
    logic               ps2_data_p0, ps2_data_p1;
    logic               fall;
    logic [3:0]         bit_cnt;
    logic [IdleW-1:0]   idle_cnt;
    logic [9:0]         shreg;
    logic               frame_vld_p3;
    logic               frame_ok_p3;
    logic [KbWidth-1:0] frame_byte_p3;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic               ovf_event;

    // Stage p0/p1: two-flop synchronizers; p2: clock history for edge detect
    assign fall = ps2_clk_p2 & ~ps2_clk_p1;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            ps2_clk_p0   <= 1'b1;
            ps2_clk_p1   <= 1'b1;
            ps2_clk_p2   <= 1'b1;
            ps2_data_p0  <= 1'b1;
            ps2_data_p1  <= 1'b1;
            bit_cnt      <= '0;
            idle_cnt     <= '0;
            frame_vld_p3 <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            ps2_clk_p0   <= ps2_clk;
            ps2_clk_p1   <= ps2_clk_p0;
            ps2_clk_p2   <= ps2_clk_p1;
            ps2_data_p0  <= ps2_data;
            ps2_data_p1  <= ps2_data_p0;
            frame_vld_p3 <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                if (bit_cnt == STOP_IDX) begin
                    bit_cnt      <= '0;
                    frame_vld_p3 <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (bit_cnt == '0) begin
                idle_cnt <= '0;
            end else if (idle_cnt == IdleW'(TIMEOUT_CYCLES)) begin
                bit_cnt <= '0;
            end else begin
                idle_cnt <= sat_inc(idle_cnt);
            end
            if (ovf_event) overflow <= 1'b1;
        end
    end

    // Stage p3: frame verdict and byte, registered on the stop-bit fall
    always_ff @(posedge clk) begin
        if (fall) begin
            shreg <= {ps2_data_p1, shreg[9:1]};
            if (bit_cnt == STOP_IDX) begin
                frame_ok_p3   <= frame_ok(shreg, ps2_data_p1);
                frame_byte_p3 <= shreg[8:1];
            end
        end
    end

    assign frame_err = frame_vld_p3 & ~frame_ok_p3;
    assign fifo_pop  = sig_rd_kb & ~fifo_empty;
    assign fifo_push = frame_vld_p3 & frame_ok_p3 & (~fifo_full | fifo_pop);
    assign ovf_event = frame_vld_p3 & frame_ok_p3 & fifo_full & ~fifo_pop;
    assign kb_ready  = ~fifo_empty;

    kbd_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .DATA_W    (KbWidth)
    ) u_fifo (
        .clk  (clk),
        .clrn (clrn),
        .push (fifo_push),
        .pop  (fifo_pop),
        .wdata(frame_byte_p3),
        .rdata(kb_rdata),
        .empty(fifo_empty),
        .full (fifo_full)
    );

endmodule
